read_port: RTL and testbench
============================

Name: read_port

Overview:
- Receive-side counterpart of the DUT write port: carries words from the FPGA state machines into the DUT.
- Accepts sync-prefixed port words from the FPGA side and strips the 32-bit sync field.
- Checks the sequence number in the sync field and buffers payloads in a small FIFO.
- Presents payloads to the DUT with a valid/consume handshake.

Parameters:
- DATA_W, 64: DUT read payload width.
- PORT_W, 96: FPGA port word width. Must be >= DATA_W+32.
- DEPTH, 4: FIFO entries. Power of 2, >= 2.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  reset, asynchronous, active-low.
- read_inst_valid  in  1  FPGA side presents a word.
- read_inst_ready  out  1  block can accept a word.
- read_port_data  in  PORT_W  [31:0] is the sync field; [DATA_W+31:32] is the payload; bits above are ignored.
- read_active  in  1  DUT consumes the head word this cycle.
- read_valid  out  1  head word available.
- read_data  out  DATA_W  head payload.
- read_level  out  $clog2(DEPTH)+1  number of occupied entries.
- seq_err  out  1  sticky sequence-mismatch flag.
- seq_clr  in  1  clears seq_err.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, pointers 0, read_level 0, read_valid 0, read_data 0, read_inst_ready 1, seq_err 0, expected sequence 0.
- Push: occurs when read_inst_valid && read_inst_ready at the clk edge.
  - Stores read_port_data[DATA_W+31:32].
  - read_inst_ready = (read_level != DEPTH), derived from registered state only.
  - When full, no push occurs even if a pop happens in the same cycle.
  - The FPGA side must hold read_inst_valid and the data stable until accepted.
- Sequence check: on each push, sync[15:0] is compared with the expected 16-bit counter.
  - Match: expected <= expected+1 (wraps 16'hFFFF -> 0).
  - Mismatch: word is still stored, seq_err <= 1, expected <= sync[15:0]+1 (resynchronise).
  - sync[31:16] is reserved and ignored.
- seq_clr: clears seq_err on the next edge. If seq_clr and a new mismatch occur in the same cycle, set wins (seq_err stays 1).
- Pop: occurs when read_active && read_valid. Head entry is retired and the read pointer advances. read_active while empty is ignored, with no state change and no error.
- Outputs:
  - read_valid = (read_level != 0).
  - read_data = mem[rd_ptr] when read_valid, else 0.
  - All outputs derive from registers; no combinational path from read_inst_valid or read_port_data to read_valid/read_data.
- Latency: a word pushed into an empty FIFO appears on read_valid/read_data in the cycle after the push edge. There is no bypass.
- Simultaneous push and pop (non-empty, non-full): read_level unchanged, both pointers advance.
- Ordering: strict FIFO order.
- Pointer wrap: pointers are $clog2(DEPTH) bits plus one wrap bit. Full is same index with opposite wrap bit; empty is pointers equal.
- read_level: always equals pushes minus pops since reset, range 0..DEPTH.
- Reset mid-operation: all buffered words are discarded immediately. The first push after reset is checked against sequence 0.

Test Plan:
- Single word: push sync=0x0000_0000, payload 0x1122_3344_5566_7788 at cycle N -> read_valid=1 and read_data=0x1122334455667788 at cycle N+1. read_active pulse -> read_valid=0, read_level=0, read_data=0.
- Fill: push 4 words with seq 0..3, read_active=0 -> read_level=4, read_inst_ready=0. A 5th word held valid is not accepted. One pop -> ready=1, and the 5th word is accepted the next cycle with read_level=4.
- Sequence error: push seq 0, 1, 5, 6 -> seq_err=1 after the third push, no further error on seq 6, all 4 payloads delivered in order. seq_clr=1 for one cycle -> seq_err=0.
- Wrap: stream 2^16+3 words with seq incrementing, including 0xFFFF -> 0x0000 -> seq_err stays 0 throughout, and payload order is preserved across many pointer wraps.
- Concurrent traffic: read_level=2, push and pop every cycle for 20 cycles -> read_level stays 2, outputs match the reference queue. read_active while empty -> no change.
- Reset mid-stream: read_level=3, assert rst_n=0 mid-cycle -> read_valid, read_level and seq_err go to 0 without waiting for a clk edge. After release, push seq 0 -> no error.

Source files
------------

// File: rtl/read_port_if.sv
// read_port_if: FPGA-to-DUT read port bundle (sync-prefixed word in, payload FIFO out)
//   master: FPGA/DUT side - drives read_inst_valid, read_port_data, read_active, seq_clr
//   slave : read_port     - drives read_inst_ready, read_valid, read_data, read_level, seq_err
interface read_port_if #(
  parameter int DATA_W = 64,
  parameter int PORT_W = 96,
  parameter int DEPTH  = 4
);
  logic                     read_inst_valid;
  logic                     read_inst_ready;
  logic [PORT_W-1:0]        read_port_data;
  logic                     read_active;
  logic                     read_valid;
  logic [DATA_W-1:0]        read_data;
  logic [$clog2(DEPTH):0]   read_level;
  logic                     seq_err;
  logic                     seq_clr;
  modport master (
    output read_inst_valid, read_port_data, read_active, seq_clr,
    input  read_inst_ready, read_valid, read_data, read_level, seq_err
  );
  modport slave (
    input  read_inst_valid, read_port_data, read_active, seq_clr,
    output read_inst_ready, read_valid, read_data, read_level, seq_err
  );
endinterface

// File: rtl/read_port.sv
// read_port: strips the 32-bit sync field, checks its sequence number and buffers payloads in a FIFO
//   clk   : block clock
//   rst_n : asynchronous active-low reset
//   bus   : read_port_if.slave - word input (valid/ready), payload output (valid/consume), level, seq_err/seq_clr
module read_port #(
  parameter int DATA_W = 64,
  parameter int PORT_W = 96,
  parameter int DEPTH  = 4
) (
  input logic clk,
  input logic rst_n,
  read_port_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [15:0]       exp_seq;
  logic              err_q, full, empty, push, pop, mismatch;
  logic [PORT_W-1:0] unused_port;
  assign unused_port = bus.read_port_data;
  // extra wrap bit distinguishes full (same index, opposite wrap) from empty
  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push     = bus.read_inst_valid && !full;
  assign pop      = bus.read_active && !empty;
  assign mismatch = bus.read_port_data[15:0] != exp_seq;
  assign bus.read_inst_ready = !full;
  assign bus.read_valid      = !empty;
  assign bus.read_level      = wr_ptr - rd_ptr;
  assign bus.read_data       = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign bus.seq_err         = err_q;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= bus.read_port_data[DATA_W+31:32];
  // a mismatch resynchronises to the received number, so the next expected is always sync+1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      exp_seq <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) exp_seq <= bus.read_port_data[15:0] + 16'd1;
      err_q <= (push && mismatch) ? 1'b1 : bus.seq_clr ? 1'b0 : err_q;
    end
endmodule

// File: tb/tb_read_port.sv
// tb_read_port: randomized + directed bench for read_port against a queue-based reference model
module tb_read_port;
  localparam int DATA_W = 64, PORT_W = 96, DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  read_port_if #(.DATA_W(DATA_W), .PORT_W(PORT_W), .DEPTH(DEPTH)) bus ();
  read_port #(.DATA_W(DATA_W), .PORT_W(PORT_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, errors = 0;
  logic [63:0] q[$];
  logic [15:0] m_seq = 16'd0;
  logic        m_err = 1'b0;
  logic        pd;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_outputs(input string tag);
    check({tag, ".level"}, 64'(bus.read_level), 64'(q.size()));
    check({tag, ".valid"}, 64'(bus.read_valid), 64'(q.size() != 0));
    check({tag, ".data"}, bus.read_data, q.size() != 0 ? q[0] : 64'd0);
    check({tag, ".ready"}, 64'(bus.read_inst_ready), 64'(q.size() != DEPTH));
    check({tag, ".seq_err"}, 64'(bus.seq_err), 64'(m_err));
  endtask
  function automatic logic [95:0] word(input logic [15:0] s, input logic [63:0] p);
    return {p, 16'($urandom), s};
  endfunction
  task automatic step(input logic v, input logic [95:0] d, input logic a, input logic c,
                      input string tag, output logic pushed);
    logic mis;
    bus.read_inst_valid = v;
    bus.read_port_data  = d;
    bus.read_active     = a;
    bus.seq_clr         = c;
    @(posedge clk);
    pushed = v && q.size() < DEPTH;
    mis    = pushed && d[15:0] != m_seq;
    if (a && q.size() > 0) void'(q.pop_front());
    if (pushed) begin
      q.push_back(d[95:32]);
      m_seq = d[15:0] + 16'd1;
    end
    m_err = mis ? 1'b1 : c ? 1'b0 : m_err;
    @(negedge clk);
    check_outputs(tag);
  endtask
  task automatic push_w(input logic [15:0] s, input logic [63:0] p, input string tag);
    logic x;
    step(1'b1, word(s, p), 1'b0, 1'b0, tag, x);
  endtask
  task automatic idle(input logic a, input logic c, input string tag);
    logic x;
    step(1'b0, 96'(0), a, c, tag, x);
  endtask
  task automatic do_reset();
    bus.read_inst_valid = 1'b0;
    bus.read_active     = 1'b0;
    bus.seq_clr         = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_seq = 16'd0;
    m_err = 1'b0;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [95:0] pend;
    logic        has_pend;
    bus.read_inst_valid = 1'b0;
    bus.read_port_data  = '0;
    bus.read_active     = 1'b0;
    bus.seq_clr         = 1'b0;
    #2;
    do_reset();
    push_w(16'h0000, 64'h1122_3344_5566_7788, "single");
    check("single.direct", bus.read_data, 64'h1122334455667788);
    idle(1'b1, 1'b0, "single_pop");
    do_reset();
    for (int i = 0; i < 4; i++) push_w(16'(i), {$urandom, $urandom}, "fill");
    pend = word(16'd4, 64'hDEAD_BEEF_0000_0005);
    step(1'b1, pend, 1'b0, 1'b0, "fill_hold", pd);
    check("fill_hold.ready", 64'(bus.read_inst_ready), 64'd0);
    step(1'b1, pend, 1'b1, 1'b0, "fill_pop", pd);
    step(1'b1, pend, 1'b0, 1'b0, "fill_accept", pd);
    check("fill_accept.level", 64'(bus.read_level), 64'd4);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, "fill_drain");
    do_reset();
    push_w(16'd0, 64'hA0, "seq");
    push_w(16'd1, 64'hA1, "seq");
    push_w(16'd5, 64'hA5, "seq");
    check("seq.err_set", 64'(bus.seq_err), 64'd1);
    push_w(16'd6, 64'hA6, "seq");
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, "seq_drain");
    idle(1'b0, 1'b1, "seq_clr");
    check("seq.err_clr", 64'(bus.seq_err), 64'd0);
    step(1'b1, word(16'h1234, 64'hBB), 1'b0, 1'b1, "seq_set_wins", pd);
    check("seq.set_wins", 64'(bus.seq_err), 64'd1);
    idle(1'b1, 1'b1, "seq_clr2");
    do_reset();
    for (int i = 0; i < 65539; i++) step(1'b1, word(16'(i), {$urandom, $urandom}), 1'b1, 1'b0, "wrap", pd);
    check("wrap.no_err", 64'(bus.seq_err), 64'd0);
    idle(1'b1, 1'b0, "wrap_drain");
    do_reset();
    push_w(16'd0, {$urandom, $urandom}, "conc");
    push_w(16'd1, {$urandom, $urandom}, "conc");
    for (int i = 0; i < 20; i++) step(1'b1, word(16'(i + 2), {$urandom, $urandom}), 1'b1, 1'b0, "conc", pd);
    check("conc.level", 64'(bus.read_level), 64'd2);
    idle(1'b1, 1'b0, "conc_drain");
    idle(1'b1, 1'b0, "conc_drain");
    idle(1'b1, 1'b0, "empty_pop");
    idle(1'b1, 1'b0, "empty_pop");
    has_pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!has_pend && $urandom_range(0, 2) != 0) begin
        pend = word($urandom_range(0, 9) == 0 ? 16'($urandom) : m_seq, {$urandom, $urandom});
        has_pend = 1'b1;
      end
      step(has_pend, pend, 1'($urandom), $urandom_range(0, 15) == 0, "rand", pd);
      if (pd) has_pend = 1'b0;
    end
    do_reset();
    push_w(16'd0, 64'hC0, "midrst");
    push_w(16'd1, 64'hC1, "midrst");
    push_w(16'd7, 64'hC7, "midrst");
    bus.read_inst_valid = 1'b0;
    bus.read_active     = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.valid", 64'(bus.read_valid), 64'd0);
    check("midrst.level", 64'(bus.read_level), 64'd0);
    check("midrst.err", 64'(bus.seq_err), 64'd0);
    q.delete();
    m_seq = 16'd0;
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_w(16'd0, 64'hD0, "post_rst");
    check("post_rst.err", 64'(bus.seq_err), 64'd0);
    idle(1'b1, 1'b0, "post_rst_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
